// File: rtl/seq_adder_display_pkg.sv
// Shared definitions for the sequential adder with multiplexed 7-segment display:
// controller state type, segment codes (active-low, seg[6]=g ... seg[0]=a)
// and a helper that counts the decimal digits of a value.
package seq_adder_display_pkg;

   // Controller states: wait for a load, shift the sum through the
   // double-dabble converter, then publish the converted digits.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   // Active-low segment patterns for the decimal digits.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   // All segments off: used for blanked digits and non-decimal nibbles.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Number of decimal digits needed to print value (0 needs one digit).
   function automatic int dec_digits(input int unsigned value);
      int          n;
      int unsigned v;
      n = 1;
      v = value;
      while (v >= 10) begin
         v = v / 10;
         n = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational nibble-to-segment decoder with a blank override.
// Anything other than 0..9, or a blanked digit, turns all segments off.
module seg7_decode
   import seq_adder_display_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   // Map the nibble onto its active-low segment pattern.
   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seq_adder_display.sv
// Sequential adder with decimal display.
// A load in IDLE latches a+b (carry kept), converts it to BCD with a
// one-bit-per-cycle double-dabble, and then publishes all digits at once to
// a display register. An independent prescaler scans the digits across a
// multiplexed, active-low 7-segment display, with optional leading-zero
// blanking.
module seq_adder_display
   import seq_adder_display_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              load,
   output logic              busy,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int SUM_W = WIDTH + 1;
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("seq_adder_display: WIDTH must be in 2..16");
   end
   if (DIGITS < dec_digits((2 ** (WIDTH + 1)) - 1)) begin : g_bad_digits
      $error("seq_adder_display: DIGITS too small for the largest sum");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh
      $error("seq_adder_display: REFRESH_DIV must be at least 2");
   end

   // ------------------------------------------------------------------
   // Controller and datapath state
   // ------------------------------------------------------------------
   state_t             r_state;
   state_t             w_state_next;
   logic               w_accept;
   logic               w_shift;
   logic               w_commit;

   logic [SUM_W-1:0]   r_sum;
   logic [BCD_W-1:0]   r_bcd;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [BCD_W-1:0]   r_disp;
   logic               w_unused_bcd_msb;

   // Next-state and control decode for the add/convert/commit sequence.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_shift      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_accept     = 1'b1;
               w_state_next = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            w_shift = 1'b1;
            // The shift happening now is the last of WIDTH+1.
            if (r_bit_cnt == CNT_W'(WIDTH)) begin
               w_state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register; reset wins over any load on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   assign busy = (r_state != ST_IDLE);

   // Double-dabble correction: each BCD nibble of 5 or more gets +3 so the
   // following left shift carries correctly into the next decade.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                    ? (r_bcd[gi*4 +: 4] + 4'd3)
                                    : r_bcd[gi*4 +: 4];
   end

   // The top BCD bit falls off the end of the shift; with enough digits it
   // is always zero.
   assign w_unused_bcd_msb = w_bcd_adj[BCD_W-1];

   // Latch the sum on accept, then shift it MSB-first into the BCD register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum     <= '0;
         r_bcd     <= '0;
         r_bit_cnt <= '0;
      end else if (w_accept) begin
         r_sum     <= SUM_W'(a) + SUM_W'(b);
         r_bcd     <= '0;
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         r_sum     <= {r_sum[SUM_W-2:0], 1'b0};
         r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_sum[SUM_W-1]};
         r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
   end

   // Display register: only ever loaded with a complete conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp <= '0;
      end else if (w_commit) begin
         r_disp <= r_bcd;
      end
   end

   // ------------------------------------------------------------------
   // Display scanning
   // ------------------------------------------------------------------
   logic [PRE_W-1:0]  r_presc;
   logic [IDX_W-1:0]  r_digit_idx;
   logic [DIGITS-1:0] w_blank;
   logic              w_zero_run;
   logic [3:0]        w_sel_nib;
   logic              w_sel_blank;
   logic [DIGITS-1:0] w_an;

   // Free-running prescaler; the digit index steps on its terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc     <= '0;
         r_digit_idx <= '0;
      end else if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
         r_presc <= '0;
         if (r_digit_idx == IDX_W'(DIGITS - 1)) begin
            r_digit_idx <= '0;
         end else begin
            r_digit_idx <= r_digit_idx + IDX_W'(1);
         end
      end else begin
         r_presc <= r_presc + PRE_W'(1);
      end
   end

   // Leading-zero detection from the top digit down; digit 0 always shows.
   always_comb begin
      w_blank    = '0;
      w_zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_disp[i*4 +: 4] == 4'd0);
         if (BLANK_LZ != 0 && i != 0) begin
            w_blank[i] = w_zero_run;
         end
      end
   end

   // Select the scanned digit and drive its active-low enable.
   always_comb begin
      w_sel_nib   = '0;
      w_sel_blank = 1'b1;
      w_an        = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_digit_idx == IDX_W'(i)) begin
            w_sel_nib   = r_disp[i*4 +: 4];
            w_sel_blank = w_blank[i];
            w_an[i]     = 1'b0;
         end
      end
   end

   assign an = w_an;

   seg7_decode u_seg7_decode (
      .i_nibble (w_sel_nib),
      .i_blank  (w_sel_blank),
      .o_seg    (seg)
   );

endmodule

// File: tb/tb_seq_adder_display.sv
// Self-checking bench for seq_adder_display (WIDTH=8, DIGITS=3, REFRESH_DIV=4).
// A second instance with leading-zero blanking disabled shares the inputs.
// Expected display contents come from plain decimal arithmetic on a+b.
module tb_seq_adder_display;

   localparam int W  = 8;
   localparam int D  = 3;
   localparam int RD = 4;

   localparam logic [6:0] SEG_TAB [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy, busy_nb;
   logic [6:0]   seg, seg_nb;
   logic [D-1:0] an, an_nb;

   int checks = 0;
   int errors = 0;
   int tb_cyc = 0;   // edges since the last reset edge
   int cur_val = 0;  // value the display is expected to show

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) tb_cyc <= 0;
      else     tb_cyc <= tb_cyc + 1;
   end

   seq_adder_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .load(load),
      .busy(busy), .seg(seg), .an(an)
   );

   seq_adder_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD), .BLANK_LZ(0)) u_dut_nb (
      .clk(clk), .rst(rst), .a(a), .b(b), .load(load),
      .busy(busy_nb), .seg(seg_nb), .an(an_nb)
   );

   // Reference: segment pattern of decimal digit idx of val.
   function automatic logic [6:0] model_seg(input int val, input bit blz, input int idx);
      int p;
      p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (blz && idx > 0 && val < p) return 7'b1111111;
      return SEG_TAB[(val / p) % 10];
   endfunction

   function automatic logic [D-1:0] model_an(input int idx);
      logic [D-1:0] v;
      v = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   function automatic int scan_idx();
      return (tb_cyc / RD) % D;
   endfunction

   // Pulse load for one cycle and count the cycles busy stays high.
   task automatic run_load(input int va, input int vb, output int nbusy);
      @(negedge clk);
      a = W'(va); b = W'(vb); load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      nbusy = 0;
      while (busy === 1'b1 && nbusy < 40) begin
         nbusy++;
         @(negedge clk);
      end
      $display("load a=%0d b=%0d busy_cycles=%0d expected_sum=%0d", va, vb, nbusy, va + vb);
   endtask

   task automatic test_reset();
      int idx;
      rst = 1'b1; load = 1'b1; a = 8'd9; b = 8'd9;
      repeat (3) @(negedge clk);
      rst = 1'b0; load = 1'b0;
      cur_val = 0;
      checks++;
      if (busy !== 1'b0 || an !== 3'b110 || seg !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_state: busy=%b an=%b seg=%b, expected busy=0 an=110 seg=1000000", busy, an, seg);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_load_ignored: busy=%b, expected 0", busy);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         idx = scan_idx();
         checks++;
         if (seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx) || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_scan: digit %0d seg=%b an=%b busy=%b, expected seg=%b an=%b busy=0",
                     idx, seg, an, busy, model_seg(cur_val, 1'b1, idx), model_an(idx));
         end
      end
   endtask

   task automatic test_max_sum();
      int nb, idx;
      run_load(255, 255, nb);
      cur_val = 510;
      checks++;
      if (nb !== 10) begin
         errors++;
         $display("FAIL max_busy: busy_cycles=%0d, expected 10", nb);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         idx = scan_idx();
         checks++;
         if (seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx)) begin
            errors++;
            $display("FAIL max_scan: digit %0d seg=%b an=%b, expected seg=%b an=%b",
                     idx, seg, an, model_seg(cur_val, 1'b1, idx), model_an(idx));
         end
      end
   endtask

   task automatic test_small_sum();
      int nb, idx;
      run_load(7, 3, nb);
      cur_val = 10;
      checks++;
      if (nb !== 10) begin
         errors++;
         $display("FAIL small_busy: busy_cycles=%0d, expected 10", nb);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         idx = scan_idx();
         checks++;
         if (seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx)) begin
            errors++;
            $display("FAIL small_scan: digit %0d seg=%b an=%b, expected seg=%b an=%b",
                     idx, seg, an, model_seg(cur_val, 1'b1, idx), model_an(idx));
         end
      end
   endtask

   task automatic test_random();
      int nb, idx, ra, rb;
      for (int t = 0; t < 6; t++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         if (t == 0) ra = 0;
         if (t == 0) rb = int'($urandom_range(0, 9));
         run_load(ra, rb, nb);
         cur_val = ra + rb;
         checks++;
         if (nb !== 10) begin
            errors++;
            $display("FAIL random_busy: busy_cycles=%0d, expected 10", nb);
         end
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            idx = scan_idx();
            checks++;
            if (seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx)) begin
               errors++;
               $display("FAIL random_scan: sum %0d digit %0d seg=%b an=%b, expected seg=%b an=%b",
                        cur_val, idx, seg, an, model_seg(cur_val, 1'b1, idx), model_an(idx));
            end
         end
      end
   endtask

   task automatic test_ignore_busy();
      int nb, idx;
      @(negedge clk);
      a = 8'd100; b = 8'd23; load = 1'b1;
      @(negedge clk);
      nb = 0;
      while (busy === 1'b1 && nb < 40) begin
         nb++;
         if (nb == 4) load = 1'b0;
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         @(negedge clk);
      end
      load = 1'b0;
      $display("load a=100 b=23 (extra loads while busy) busy_cycles=%0d expected_sum=123", nb);
      cur_val = 123;
      checks++;
      if (nb !== 10) begin
         errors++;
         $display("FAIL ignore_busy_cycles: busy_cycles=%0d, expected 10", nb);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         idx = scan_idx();
         checks++;
         if (seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx) || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_scan: digit %0d seg=%b an=%b busy=%b, expected seg=%b an=%b busy=0",
                     idx, seg, an, busy, model_seg(cur_val, 1'b1, idx), model_an(idx));
         end
      end
   endtask

   task automatic test_back_to_back();
      int pend, idx, commits;
      logic exp_busy, prev_busy;
      pend = 0; commits = 0; prev_busy = 1'b0;
      for (int j = 0; j < 44; j++) begin
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         load = 1'b1;
         if (j % 11 == 0) begin
            pend = int'(a) + int'(b);
            $display("load a=%0d b=%0d (held load) expected_sum=%0d", a, b, pend);
         end
         @(negedge clk);
         if (j % 11 == 10) cur_val = pend;
         exp_busy = (j % 11 != 10);
         if (prev_busy && !busy) commits++;
         prev_busy = busy;
         idx = scan_idx();
         checks++;
         if (busy !== exp_busy || seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx)) begin
            errors++;
            $display("FAIL back_to_back: cycle %0d busy=%b seg=%b an=%b, expected busy=%b seg=%b an=%b",
                     j, busy, seg, an, exp_busy, model_seg(cur_val, 1'b1, idx), model_an(idx));
         end
      end
      load = 1'b0;
      checks++;
      if (commits !== 4) begin
         errors++;
         $display("FAIL back_to_back_commits: commits=%0d, expected 4", commits);
      end
   endtask

   task automatic test_reset_mid();
      int idx;
      @(negedge clk);
      a = 8'd200; b = 8'd100; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      $display("load a=200 b=100 (reset during conversion) expected_sum=discarded");
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_start: busy=%b, expected 1", busy);
      end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cur_val = 0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_busy: busy=%b, expected 0", busy);
      end
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         idx = scan_idx();
         checks++;
         if (seg !== model_seg(cur_val, 1'b1, idx) || an !== model_an(idx) || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan: digit %0d seg=%b an=%b busy=%b, expected seg=%b an=%b busy=0",
                     idx, seg, an, busy, model_seg(cur_val, 1'b1, idx), model_an(idx));
         end
      end
   endtask

   task automatic test_no_blank();
      int nb, idx;
      run_load(0, 5, nb);
      cur_val = 5;
      checks++;
      if (nb !== 10 || busy_nb !== 1'b0) begin
         errors++;
         $display("FAIL no_blank_busy: busy_cycles=%0d busy_nb=%b, expected 10 and 0", nb, busy_nb);
      end
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         idx = scan_idx();
         checks++;
         if (seg_nb !== model_seg(cur_val, 1'b0, idx) || an_nb !== model_an(idx)) begin
            errors++;
            $display("FAIL no_blank_scan: digit %0d seg=%b an=%b, expected seg=%b an=%b",
                     idx, seg_nb, an_nb, model_seg(cur_val, 1'b0, idx), model_an(idx));
         end
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; a = '0; b = '0;
      test_reset();
      test_max_sum();
      test_small_sum();
      test_random();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_no_blank();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded 500000, expected completion earlier");
      $fatal(1);
   end

endmodule
